cra_seq_ctrl: RTL and testbench
===============================

CRA_SEQ_CTRL -- requirements
Module: cra_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand width; the sum is WIDTH+1 bits.
REQ-002 Parameter: RUN_CYCLES, 4, cycles dp_run is held low per operation; legal range 1..15.
REQ-003 Port: Clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port: Reset  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  2  per-requester operation request; bit i belongs to requester i.
REQ-006 Port: din0 / din1  input  WIDTH  operand of requester 0 / 1.
REQ-007 Port: gnt  output  2  one-hot grant, high for the whole operation of the granted requester.
REQ-008 Port: done  output  2  one-cycle completion pulse to the granted requester.
REQ-009 Port: result  output  WIDTH+1  captured datapath sum; holds until the next capture.
REQ-010 Port: dp_din  output  WIDTH  operand driven to the adder datapath.
REQ-011 Port: dp_loadb  output  1  active-low B-register load strobe to the datapath.
REQ-012 Port: dp_run  output  1  active-low execute strobe to the datapath.
REQ-013 Port: dp_sum  input  WIDTH+1  datapath register output (reg_out).

Function
REQ-014 FSM states: IDLE, LOAD, EXEC, DONE.
REQ-015 IDLE: if any req bit is high, pick a winner, latch its din into the operand register, set gnt, and go to LOAD; otherwise stay in IDLE.
REQ-016 Arbitration: round-robin, 2 requesters; when both request, grant the one not granted last; a lone requester is always granted.
REQ-017 LOAD: one cycle; dp_loadb=0, dp_din=latched operand; then go to EXEC.
REQ-018 EXEC: dp_run=0 for exactly RUN_CYCLES cycles (internal down-counter); dp_din stays stable; then go to DONE.
REQ-019 DONE: one cycle; result<=dp_sum registered at DONE entry; done[winner]=1; gnt cleared at exit; return to IDLE.
REQ-020 Latency: req sampled at edge k -> gnt visible after edge k, done high during cycle k+2+RUN_CYCLES; result valid in the same cycle as done.
REQ-021 Minimum gap: at least one IDLE cycle between consecutive operations.
REQ-022 Operands are sampled only at grant; changes to din during an operation are ignored.
REQ-023 A requester dropping req mid-operation is ignored; the operation completes and done still pulses.
REQ-024 Outside LOAD, dp_loadb=1; outside EXEC, dp_run=1; at most one strobe is low in any cycle.
REQ-025 gnt and done are each one-hot or zero; done[i] implies gnt[i] in the same cycle.

Reset
REQ-026 Reset low forces, immediately and asynchronously: state=IDLE, gnt=0, done=0, result=0, dp_loadb=1, dp_run=1, dp_din=0, counter=0, round-robin pointer favours requester 0.
REQ-027 Reset mid-operation aborts it; no done is issued for the aborted operation.

Configuration
REQ-028 Macro CRA_SEQ_OVF_EN defined: adds output port ovf (1 bit). ovf equals dp_sum[WIDTH] captured in DONE, is high only during the done cycle, and is 0 after reset.
REQ-029 Macro not defined: no ovf port; result[WIDTH] still carries the carry bit.

Structure
REQ-030 Shared package cra_pkg holds the state enum type, the default WIDTH, and the default RUN_CYCLES constant.
REQ-031 Round-robin logic is a sub-module named rr_arb2 (inputs req[1:0] and last-grant; output one-hot winner).

Verification (bench drives an accumulating datapath model: sum <= sum + B on each run)
REQ-032 Bench covers these cases:
- Reset, then req=01 with din0=0x0001: dp_loadb low for 1 cycle, dp_run low for 4 cycles, done=01 6 cycles after req, result=0x00001.
- Then req=10 with din1=0x0002: gnt=10, done=10, result=0x00003.
- req=11 held, last grant=1: grants alternate 01, 10, 01, with one IDLE cycle between operations.
- Accumulator 0xFFFF plus din0=0x0001: result=0x10000; ovf=1 in the done cycle when CRA_SEQ_OVF_EN is defined.
- Reset asserted in the 2nd EXEC cycle: dp_run=1, gnt=00, done=00, result=0 immediately; no done pulse follows.
- req0 dropped and din0 changed during EXEC: done still pulses, and the sum uses the operand sampled at grant.

Source files
------------

// File: rtl/cra_pkg.sv
// Shared types and defaults for the CRA sequencer controller.
// Optional overflow output is enabled with macro CRA_SEQ_OVF_EN.
package cra_pkg;

  localparam int unsigned CRA_WIDTH      = 16;
  localparam int unsigned CRA_RUN_CYCLES = 4;
  localparam int unsigned CRA_CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } cra_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; combinational one-hot winner.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_win_c
);

  // i_last is the index of the requester granted most recently
  always_comb begin
    o_win_c = 2'b00;
    case (i_req)
      2'b01:   o_win_c = 2'b01;
      2'b10:   o_win_c = 2'b10;
      2'b11:   o_win_c = i_last ? 2'b01 : 2'b10;
      default: o_win_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/cra_seq_ctrl.sv
// Sequencer for a shared carry-ripple adder datapath with two requesters.
// Define CRA_SEQ_OVF_EN to add the ovf output (carry flag in the done cycle).
module cra_seq_ctrl
  import cra_pkg::*;
#(
  parameter int unsigned WIDTH      = CRA_WIDTH,
  parameter int unsigned RUN_CYCLES = CRA_RUN_CYCLES
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [WIDTH:0]   result,
  output logic [WIDTH-1:0] dp_din,
  output logic             dp_loadb,
  output logic             dp_run,
  input  logic [WIDTH:0]   dp_sum
`ifdef CRA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = CRA_CNT_W;

  cra_state_e       r_state;
  cra_state_e       w_state_nxt;
  logic [1:0]       r_gnt,    w_gnt_nxt;
  logic [1:0]       r_done,   w_done_nxt;
  logic [WIDTH:0]   r_result, w_result_nxt;
  logic [WIDTH-1:0] r_opnd,   w_opnd_nxt;
  logic             r_loadb,  w_loadb_nxt;
  logic             r_run,    w_run_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic             r_last,   w_last_nxt;
  logic [1:0]       w_win;
`ifdef CRA_SEQ_OVF_EN
  logic             r_ovf,    w_ovf_nxt;
`endif

  rr_arb2 u_arb (
    .i_req   (req),
    .i_last  (r_last),
    .o_win_c (w_win)
  );

  // Next-state and next-output logic; strobes registered so they align with state
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_done_nxt   = 2'b00;
    w_result_nxt = r_result;
    w_opnd_nxt   = r_opnd;
    w_loadb_nxt  = 1'b1;
    w_run_nxt    = 1'b1;
    w_cnt_nxt    = r_cnt;
    w_last_nxt   = r_last;
`ifdef CRA_SEQ_OVF_EN
    w_ovf_nxt    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt = ST_LOAD;
          w_gnt_nxt   = w_win;
          w_opnd_nxt  = w_win[1] ? din1 : din0;
          w_loadb_nxt = 1'b0;
          w_last_nxt  = w_win[1];
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_EXEC;
        w_run_nxt   = 1'b0;
        w_cnt_nxt   = CNT_W'(RUN_CYCLES);
      end
      ST_EXEC: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt  = ST_DONE;
          w_cnt_nxt    = '0;
          w_done_nxt   = r_gnt;
          w_result_nxt = dp_sum;
`ifdef CRA_SEQ_OVF_EN
          w_ovf_nxt    = dp_sum[WIDTH];
`endif
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          w_run_nxt = 1'b0;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 2'b00;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 2'b00;
      end
    endcase
  end

  // State and output registers; pointer resets to favour requester 0
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 2'b00;
      r_done   <= 2'b00;
      r_result <= '0;
      r_opnd   <= '0;
      r_loadb  <= 1'b1;
      r_run    <= 1'b1;
      r_cnt    <= '0;
      r_last   <= 1'b1;
`ifdef CRA_SEQ_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
      r_opnd   <= w_opnd_nxt;
      r_loadb  <= w_loadb_nxt;
      r_run    <= w_run_nxt;
      r_cnt    <= w_cnt_nxt;
      r_last   <= w_last_nxt;
`ifdef CRA_SEQ_OVF_EN
      r_ovf    <= w_ovf_nxt;
`endif
    end
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign result   = r_result;
  assign dp_din   = r_opnd;
  assign dp_loadb = r_loadb;
  assign dp_run   = r_run;
`ifdef CRA_SEQ_OVF_EN
  assign ovf      = r_ovf;
`endif

endmodule

// File: tb/tb_cra_seq_ctrl.sv
// Self-checking bench for cra_seq_ctrl with an accumulating datapath model
// (B loads on dp_loadb low, sum += B once per dp_run low pulse).
module tb_cra_seq_ctrl;

  localparam int unsigned W = 16;
  localparam int unsigned R = 4;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [1:0]   req;
  logic [W-1:0] din0, din1;
  logic [1:0]   gnt, done;
  logic [W:0]   result;
  logic [W-1:0] dp_din;
  logic         dp_loadb, dp_run;
  logic [W:0]   dp_sum;
`ifdef CRA_SEQ_OVF_EN
  logic         ovf;
`endif

  cra_seq_ctrl #(.WIDTH(W), .RUN_CYCLES(R)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .req      (req),
    .din0     (din0),
    .din1     (din1),
    .gnt      (gnt),
    .done     (done),
    .result   (result),
    .dp_din   (dp_din),
    .dp_loadb (dp_loadb),
    .dp_run   (dp_run),
    .dp_sum   (dp_sum)
`ifdef CRA_SEQ_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 Clk = ~Clk;

  // Accumulating datapath: one addition per dp_run low pulse
  logic [W-1:0] dp_b;
  logic [W:0]   dp_acc;
  logic         run_q;
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      dp_b   <= '0;
      dp_acc <= '0;
      run_q  <= 1'b1;
    end else begin
      if (!dp_loadb) dp_b <= dp_din;
      if (!dp_run && run_q) dp_acc <= dp_acc + {1'b0, dp_b};
      run_q <= dp_run;
    end
  end
  assign dp_sum = dp_acc;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [W:0] exp_acc;
  int         last_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b0;
    req   = 2'b00;
    #1;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_loadb", 32'(dp_loadb), 32'(1));
    chk("rst_run", 32'(dp_run), 32'(1));
    chk("rst_dp_din", 32'(dp_din), 32'(0));
`ifdef CRA_SEQ_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'(0));
`endif
    @(negedge Clk);
    Reset   = 1'b1;
    exp_acc = '0;
    last_g  = 1;
  endtask

  // One full operation; disturb drops the winner's req and changes din during EXEC
  task automatic do_op(input logic [1:0] rq, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input bit disturb, input bit keep);
    int         win;
    logic [W-1:0] opnd;
    logic [W:0] exp_res;
    @(negedge Clk);
    req  = rq;
    din0 = d0;
    din1 = d1;
    if (rq == 2'b11) win = (last_g == 1) ? 0 : 1;
    else             win = rq[1] ? 1 : 0;
    opnd    = (win == 1) ? d1 : d0;
    exp_res = exp_acc + {1'b0, opnd};
    @(posedge Clk); #1;
    chk("load_gnt", 32'(gnt), 32'(1) << win);
    chk("load_loadb", 32'(dp_loadb), 32'(0));
    chk("load_run", 32'(dp_run), 32'(1));
    chk("load_dp_din", 32'(dp_din), 32'(opnd));
    chk("load_done", 32'(done), 32'(0));
    for (int i = 0; i < int'(R); i++) begin
      @(posedge Clk); #1;
      if (disturb && i == 0) begin
        req  = rq & ~(2'b01 << win);
        din0 = ~d0;
        din1 = ~d1;
      end
      chk("exec_run", 32'(dp_run), 32'(0));
      chk("exec_loadb", 32'(dp_loadb), 32'(1));
      chk("exec_gnt", 32'(gnt), 32'(1) << win);
      chk("exec_dp_din", 32'(dp_din), 32'(opnd));
      chk("exec_done", 32'(done), 32'(0));
    end
    @(posedge Clk); #1;
    chk("done_done", 32'(done), 32'(1) << win);
    chk("done_gnt", 32'(gnt), 32'(1) << win);
    chk("done_result", 32'(result), 32'(exp_res));
    chk("done_run", 32'(dp_run), 32'(1));
    chk("done_loadb", 32'(dp_loadb), 32'(1));
`ifdef CRA_SEQ_OVF_EN
    chk("done_ovf", 32'(ovf), 32'(exp_res[W]));
`endif
    @(posedge Clk); #1;
    chk("idle_gnt", 32'(gnt), 32'(0));
    chk("idle_done", 32'(done), 32'(0));
    chk("idle_result", 32'(result), 32'(exp_res));
`ifdef CRA_SEQ_OVF_EN
    chk("idle_ovf", 32'(ovf), 32'(0));
`endif
    exp_acc = exp_res;
    last_g  = win;
    if (!keep) req = 2'b00;
  endtask

  initial begin
    logic [1:0] rq;
    Reset = 1'b0;
    req   = 2'b00;
    din0  = '0;
    din1  = '0;
    exp_acc = '0;
    last_g  = 1;
    repeat (2) @(posedge Clk);
    apply_reset();

    // Directed: single requesters, then contention with req held
    do_op(2'b01, 16'h0001, 16'h0000, 1'b0, 1'b0);
    chk("dir_r1", 32'(result), 32'h00001);
    do_op(2'b10, 16'h0000, 16'h0002, 1'b0, 1'b0);
    chk("dir_r2", 32'(result), 32'h00003);
    do_op(2'b11, 16'h0010, 16'h0020, 1'b0, 1'b1);
    do_op(2'b11, 16'h0010, 16'h0020, 1'b0, 1'b1);
    do_op(2'b11, 16'h0010, 16'h0020, 1'b0, 1'b0);
    chk("dir_rr", 32'(result), 32'h00043);

    // Carry out of the top operand bit
    apply_reset();
    do_op(2'b01, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    do_op(2'b01, 16'h0001, 16'h0000, 1'b0, 1'b0);
    chk("dir_carry", 32'(result), 32'h10000);

    // Request dropped and operand changed mid-operation
    do_op(2'b01, 16'h1234, 16'h0000, 1'b1, 1'b0);

    // Reset in the second EXEC cycle aborts without done
    @(negedge Clk);
    req  = 2'b01;
    din0 = 16'h0055;
    repeat (3) @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    chk("abort_run", 32'(dp_run), 32'(1));
    chk("abort_gnt", 32'(gnt), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_result", 32'(result), 32'(0));
    chk("abort_loadb", 32'(dp_loadb), 32'(1));
    @(negedge Clk);
    req     = 2'b00;
    Reset   = 1'b1;
    exp_acc = '0;
    last_g  = 1;
    for (int i = 0; i < int'(R) + 4; i++) begin
      @(posedge Clk); #1;
      chk("abort_no_done", 32'(done), 32'(0));
      chk("abort_no_gnt", 32'(gnt), 32'(0));
    end
    do_op(2'b11, 16'h0007, 16'h0009, 1'b0, 1'b0);

    // Randomized operations against the reference model
    for (int n = 0; n < 24; n++) begin
      rq = 2'($urandom_range(1, 3));
      do_op(rq, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
